uart_byte_loader: RTL and testbench

- Upstream feeder for the on-board memory programming stage: receives an 8N1 UART stream from the host and presents each received byte on a parallel output with a one-cycle valid strobe.
- Counts accepted bytes and raises a sticky done flag after a full memory image of LOAD_BYTES bytes.
- Lets a PC download a program image into on-chip RAM over a single serial pin on the 50 MHz board clock.

---
 rtl/uart_byte_loader.sv | 159 +++++++++++++++
 tb/tb_uart_byte_loader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_loader.sv
// uart_byte_loader
//   Receives an 8N1 UART stream on rx_in and presents each accepted byte on
//   data_out with a one-cycle data_valid_out strobe. Accepted bytes are
//   counted; once LOAD_BYTES bytes have been accepted load_done_out goes high
//   and stays high, and any further bytes are discarded.
//
//   Handshake: data_valid_out is a pure strobe with no back-pressure. The
//   consumer must take data_out in the cycle data_valid_out is high.
//   data_out holds its value between strobes.
//
// Ports
//   clock_in        system clock, rising edge
//   reset_N         asynchronous active-low reset
//   rx_in           UART serial input (asynchronous, idle high)
//   data_out        last accepted byte
//   data_valid_out  one-cycle strobe qualifying data_out
//   byte_count_out  bytes accepted since reset (saturates at LOAD_BYTES)
//   load_done_out   sticky, high once LOAD_BYTES bytes were accepted
//   frame_err_out   sticky, a stop bit was sampled low
module uart_byte_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int LOAD_BYTES   = 256
) (
  input  logic       clock_in,
  input  logic       reset_N,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid_out,
  output logic [8:0] byte_count_out,
  output logic       load_done_out,
  output logic       frame_err_out
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [8:0]    LOAD_N   = 9'(LOAD_BYTES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          rx_meta;
  logic          rx_s;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          emit_pend;
  logic          sample_bit;
  logic          stop_good;
  logic          stop_bad;

  // Two-flop synchronizer; flops reset to the idle (high) line level.
  always_ff @(posedge clock_in or negedge reset_N) begin
    if (!reset_N) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clock_in or negedge reset_N) begin
    if (!reset_N) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    sample_bit = 1'b0;
    stop_good  = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) state_nx = S_START;
      end
      S_START: begin
        // Re-check the line at mid start bit; a high line was a glitch.
        if (clk_cnt == CNT_MID) state_nx = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (clk_cnt == CNT_LAST) begin
          sample_bit = 1'b1;
          if (bit_idx == 3'd7) state_nx = S_STOP;
        end
      end
      S_STOP: begin
        if (clk_cnt == CNT_LAST) begin
          if (rx_s) begin
            stop_good = 1'b1;
            state_nx  = S_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_nx = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Hold here until the line returns high so a stuck-low line is not
        // read as a stream of start bits.
        if (rx_s) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Bit-period counter; restarts on every state change so each state
  // measures from its own entry.
  always_ff @(posedge clock_in or negedge reset_N) begin
    if (!reset_N) begin
      clk_cnt <= '0;
    end else if (state_nx != state || clk_cnt == CNT_LAST) begin
      clk_cnt <= '0;
    end else begin
      clk_cnt <= clk_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock_in or negedge reset_N) begin
    if (!reset_N) begin
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      if (state != S_DATA)  bit_idx <= '0;
      else if (sample_bit)  bit_idx <= bit_idx + 1'b1;
      if (sample_bit) shift <= {rx_s, shift[7:1]};  // LSB arrives first
    end
  end

  // A good stop bit schedules the output update for the following edge.
  always_ff @(posedge clock_in or negedge reset_N) begin
    if (!reset_N) begin
      emit_pend      <= 1'b0;
      data_out       <= 8'h00;
      data_valid_out <= 1'b0;
      byte_count_out <= 9'd0;
      load_done_out  <= 1'b0;
      frame_err_out  <= 1'b0;
    end else begin
      emit_pend      <= stop_good && !load_done_out;
      data_valid_out <= 1'b0;
      if (emit_pend && byte_count_out != LOAD_N) begin
        data_out       <= shift;
        data_valid_out <= 1'b1;
        byte_count_out <= byte_count_out + 9'd1;
        if (byte_count_out + 9'd1 == LOAD_N) load_done_out <= 1'b1;
      end
      if (stop_bad) frame_err_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_byte_loader.sv
// Testbench for uart_byte_loader: directed scenarios followed by random
// frames, checked against a frame-level reference model with an expected
// byte queue.
module tb_uart_byte_loader;

  localparam int CPB  = 16;
  localparam int LOAD = 4;

  logic       clock_in;
  logic       reset_N;
  logic       rx_in;
  logic [7:0] data_out;
  logic       data_valid_out;
  logic [8:0] byte_count_out;
  logic       load_done_out;
  logic       frame_err_out;

  uart_byte_loader #(.CLKS_PER_BIT(CPB), .LOAD_BYTES(LOAD)) dut (
    .clock_in       (clock_in),
    .reset_N        (reset_N),
    .rx_in          (rx_in),
    .data_out       (data_out),
    .data_valid_out (data_valid_out),
    .byte_count_out (byte_count_out),
    .load_done_out  (load_done_out),
    .frame_err_out  (frame_err_out)
  );

  // clock / reset
  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  // scoreboard state
  int         total;
  int         bad;
  logic [7:0] exp_q[$];
  int         m_cnt;     // bytes the model says were accepted
  logic       m_err;     // model framing-error flag
  logic [7:0] m_last;    // model data_out
  int         obs_cnt;   // strobes seen since reset

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: every strobe must match the head of the expected queue.
  always @(negedge clock_in) begin
    if (!reset_N) begin
      obs_cnt = 0;
    end else if (data_valid_out) begin
      obs_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", {24'd0, data_out}, 32'd0);
      end else begin
        chk("strobe_data", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
        chk("strobe_count", {23'd0, byte_count_out}, obs_cnt);
        chk("strobe_done", {31'd0, load_done_out}, (obs_cnt == LOAD) ? 32'd1 : 32'd0);
      end
    end
  end

  // driver tasks
  task automatic drive_bit(input logic v, input int n);
    rx_in = v;
    repeat (n) @(negedge clock_in);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cnt  = 0;
    m_err  = 1'b0;
    m_last = 8'h00;
  endtask

  task automatic do_reset();
    reset_N = 1'b0;
    rx_in   = 1'b1;
    model_reset();
    repeat (3) @(negedge clock_in);
    reset_N = 1'b1;
    repeat (2) @(negedge clock_in);
  endtask

  // Sends one frame; stop_ok=0 holds the stop bit low for stop_low cycles.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                            input int stop_low, input int gap);
    if (stop_ok) begin
      if (m_cnt < LOAD) begin
        exp_q.push_back(b);
        m_cnt++;
        m_last = b;
      end
    end else begin
      m_err = 1'b1;
    end
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
    if (stop_ok) begin
      drive_bit(1'b1, CPB);
    end else begin
      drive_bit(1'b0, stop_low);
      drive_bit(1'b1, CPB);
    end
    if (gap > 0) drive_bit(1'b1, gap);
  endtask

  task automatic settle_and_check(input string tag);
    drive_bit(1'b1, 30);
    chk({tag, "_pending"}, exp_q.size(), 32'd0);
    chk({tag, "_count"}, {23'd0, byte_count_out}, m_cnt);
    chk({tag, "_done"}, {31'd0, load_done_out}, (m_cnt == LOAD) ? 32'd1 : 32'd0);
    chk({tag, "_ferr"}, {31'd0, frame_err_out}, {31'd0, m_err});
    chk({tag, "_hold"}, {24'd0, data_out}, {24'd0, m_last});
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset_N = 1'b0;
    rx_in   = 1'b1;
    model_reset();
    @(negedge clock_in);
    do_reset();

    // reset state
    chk("rst_data", {24'd0, data_out}, 32'd0);
    chk("rst_valid", {31'd0, data_valid_out}, 32'd0);
    chk("rst_count", {23'd0, byte_count_out}, 32'd0);

    // single byte
    send_frame(8'hA5, 1'b1, 0, 0);
    settle_and_check("single");

    // asynchronous reset, observed before any clock edge
    #2 reset_N = 1'b0;
    #1;
    chk("async_data", {24'd0, data_out}, 32'd0);
    chk("async_count", {23'd0, byte_count_out}, 32'd0);
    chk("async_valid", {31'd0, data_valid_out}, 32'd0);
    chk("async_done", {31'd0, load_done_out}, 32'd0);
    chk("async_ferr", {31'd0, frame_err_out}, 32'd0);
    @(negedge clock_in);
    do_reset();

    // glitch rejection, then a good frame
    drive_bit(1'b0, 5);
    drive_bit(1'b1, 30);
    chk("glitch_count", {23'd0, byte_count_out}, 32'd0);
    send_frame(8'h3C, 1'b1, 0, 0);
    settle_and_check("glitch");

    // framing error, then a good frame
    do_reset();
    send_frame(8'h55, 1'b0, 40, 0);
    settle_and_check("ferr");
    send_frame(8'h12, 1'b1, 0, 0);
    settle_and_check("ferr_next");

    // full image, fifth byte discarded
    do_reset();
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 0, 0);
    settle_and_check("image");

    // reset during data bit 3 of 0xFF
    do_reset();
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, CPB);
    drive_bit(1'b1, CPB / 2);
    do_reset();
    send_frame(8'h81, 1'b1, 0, 0);
    settle_and_check("midrst");

    // random frames
    do_reset();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) do_reset();
      send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 6) != 0),
                 $urandom_range(CPB, 3 * CPB), $urandom_range(0, 20));
      if (n % 5 == 4) settle_and_check("rand");
    end
    settle_and_check("rand_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
